// File: rtl/abc_seq_pkg.sv
// Shared definitions for the A/B/C stimulus generator: FSM state encoding,
// per-mode step-to-output tables and last-step indices.
package abc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One-hot output selects, packed as {A,B,C}
  localparam logic [2:0] SEL_A = 3'b100;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_C = 3'b001;

  localparam logic [2:0] LAST_STEP_M0 = 3'd4;
  localparam logic [2:0] LAST_STEP_M1 = 3'd2;

  // Element 0 sits in the least significant 3 bits
  localparam logic [14:0] SEQ_TBL_M0 = {SEL_C, SEL_B, SEL_A, SEL_B, SEL_A};
  localparam logic [14:0] SEQ_TBL_M1 = {6'b000000, SEL_C, SEL_B, SEL_A};

  function automatic logic [2:0] seq_sel(input logic mode, input logic [2:0] step);
    logic [14:0] tbl_bits;
    int idx;
    tbl_bits = mode ? SEQ_TBL_M1 : SEQ_TBL_M0;
    idx = int'(step) * 3;
    if (step > LAST_STEP_M0)
      return 3'b000;
    return tbl_bits[idx +: 3];
  endfunction

  function automatic logic [2:0] last_step(input logic mode);
    return mode ? LAST_STEP_M1 : LAST_STEP_M0;
  endfunction

endpackage

// File: rtl/seq_cycle_cnt.sv
// Down-counter pacing the PULSE and GAP phases; saturates at zero.
module seq_cycle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_reg <= 8'd0;
    else if (load)
      cnt_reg <= load_val;
    else if (cnt_reg != 8'd0)
      cnt_reg <= cnt_reg - 8'd1;
  end

  assign zero = (cnt_reg == 8'd0);

endmodule

// File: rtl/abc_seq_gen.sv
// Emits a paced A/B/C pulse sequence (ABABC or ABC) on request, with abort,
// busy and a one-cycle done strobe. All outputs are registered.
module abc_seq_gen
  import abc_seq_pkg::*;
#(
  parameter int PULSE_CYC = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic [2:0] step
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

  state_t     state_reg, state_next;
  logic       mode_reg, mode_next;
  logic [2:0] step_reg, step_next;
  logic [2:0] sel_reg, sel_next;
  logic       busy_reg, done_reg;
  logic       cnt_load, cnt_zero;
  logic [7:0] cnt_load_val;

  seq_cycle_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    step_next  = step_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = PULSE;
          mode_next  = mode;
          step_next  = 3'd0;
        end
      end
      PULSE: begin
        if (abort) begin
          state_next = IDLE;
          step_next  = 3'd0;
        end else if (cnt_zero) begin
          state_next = GAP;
        end
      end
      GAP: begin
        if (abort) begin
          state_next = IDLE;
          step_next  = 3'd0;
        end else if (cnt_zero) begin
          if (step_reg == last_step(mode_reg)) begin
            state_next = DONE;
            step_next  = 3'd0;
          end else begin
            state_next = PULSE;
            step_next  = step_reg + 3'd1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        step_next  = 3'd0;
      end
      default: begin
        state_next = IDLE;
        step_next  = 3'd0;
      end
    endcase

    // Counter is reloaded on every state change; only PULSE/GAP entries matter
    cnt_load     = (state_next != state_reg);
    cnt_load_val = (state_next == GAP) ? GAP_LOAD : PULSE_LOAD;

    sel_next = (state_next == PULSE) ? seq_sel(mode_next, step_next) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      mode_reg  <= 1'b0;
      step_reg  <= 3'd0;
      sel_reg   <= 3'b000;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      step_reg  <= step_next;
      sel_reg   <= sel_next;
      busy_reg  <= (state_next == PULSE) || (state_next == GAP);
      done_reg  <= (state_next == DONE);
    end
  end

  assign {A, B, C} = sel_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign step      = step_reg;

endmodule

// File: tb/tb_abc_seq_gen.sv
// Directed bench for abc_seq_gen: default and widened-timing instances,
// per-cycle trace comparison, plus a behavioural ABC detector and one-hot watch.
module tb_abc_seq_gen;

  logic       clk, rst, start, mode, abort;
  logic       a0, b0, c0, busy0, done0;
  logic [2:0] step0;
  logic       a1, b1, c1, busy1, done1;
  logic [2:0] step1;

  int checks;
  int passed;
  int y_count;
  int multi_count;

  abc_seq_gen u_dflt (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .A(a0), .B(b0), .C(c0), .busy(busy0), .done(done0), .step(step0)
  );

  abc_seq_gen #(.PULSE_CYC(3), .GAP_CYC(2)) u_wide (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1), .step(step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic byte letter(input logic a, input logic b, input logic c);
    int n;
    n = int'(a === 1'b1) + int'(b === 1'b1) + int'(c === 1'b1);
    if (n > 1) return "X";
    if (a === 1'b1) return "A";
    if (b === 1'b1) return "B";
    if (c === 1'b1) return "C";
    if (a !== 1'b0 || b !== 1'b0 || c !== 1'b0) return "?";
    return ".";
  endfunction

  // Reference sequence detector: y fires on a C pulse preceded by A then B pulses
  byte det_prev, det_h1, det_h2, det_cur;
  always @(negedge clk) begin
    det_cur = letter(a0, b0, c0);
    if (rst !== 1'b1) begin
      det_h1 = ".";
      det_h2 = ".";
    end else if (det_cur != det_prev && (det_cur == "A" || det_cur == "B" || det_cur == "C")) begin
      if (det_cur == "C" && det_h1 == "B" && det_h2 == "A")
        y_count++;
      det_h2 = det_h1;
      det_h1 = det_cur;
    end
    det_prev = det_cur;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && (letter(a0, b0, c0) == "X" || letter(a1, b1, c1) == "X"))
      multi_count++;
  end

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({a0, b0, c0, busy0, done0, step0} !== 8'h00)
      $display("FAIL reset_dflt: got %b, expected 00000000", {a0, b0, c0, busy0, done0, step0});
    else passed++;
    checks++;
    if ({a1, b1, c1, busy1, done1, step1} !== 8'h00)
      $display("FAIL reset_wide: got %b, expected 00000000", {a1, b1, c1, busy1, done1, step1});
    else passed++;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_mode0();
    string abc = "A.B.A.B.C...", bs = "111111111100", ds = "000000000010", ss = "001122334400";
    logic [12:0] obs, exp;
    byte sd;
    int y0;
    do_reset();
    y0 = y_count;
    mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sd  = ss[k-1] - 8'h30;
      obs = {letter(a0, b0, c0), busy0, done0, step0};
      exp = {abc[k-1], bs[k-1] == 8'h31, ds[k-1] == 8'h31, sd[2:0]};
      checks++;
      if (obs !== exp)
        $display("FAIL mode0 cycle %0d: got %c/%0b/%0b/%0d, expected %c/%0b/%0b/%0d",
                 k, obs[12:5], obs[4], obs[3], obs[2:0], exp[12:5], exp[4], exp[3], exp[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (y_count !== y0 + 1) $display("FAIL mode0_detect: got %0d, expected %0d", y_count - y0, 1);
    else passed++;
  endtask

  task automatic test_mode1();
    string abc = "A.B.C...", bs = "11111100", ds = "00000010", ss = "00112200";
    logic [12:0] obs, exp;
    byte sd;
    int y0;
    do_reset();
    y0 = y_count;
    mode = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; mode = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      sd  = ss[k-1] - 8'h30;
      obs = {letter(a0, b0, c0), busy0, done0, step0};
      exp = {abc[k-1], bs[k-1] == 8'h31, ds[k-1] == 8'h31, sd[2:0]};
      checks++;
      if (obs !== exp)
        $display("FAIL mode1 cycle %0d: got %c/%0b/%0b/%0d, expected %c/%0b/%0b/%0d",
                 k, obs[12:5], obs[4], obs[3], obs[2:0], exp[12:5], exp[4], exp[3], exp[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
    checks++;
    if (y_count !== y0 + 1) $display("FAIL mode1_detect: got %0d, expected %0d", y_count - y0, 1);
    else passed++;
  endtask

  task automatic test_wide();
    string abc = "AAA..BBB..CCC....", bs = "11111111111111100";
    string ds = "00000000000000010", ss = "00000111112222200";
    logic [12:0] obs, exp;
    byte sd;
    do_reset();
    mode = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      sd  = ss[k-1] - 8'h30;
      obs = {letter(a1, b1, c1), busy1, done1, step1};
      exp = {abc[k-1], bs[k-1] == 8'h31, ds[k-1] == 8'h31, sd[2:0]};
      checks++;
      if (obs !== exp)
        $display("FAIL wide cycle %0d: got %c/%0b/%0b/%0d, expected %c/%0b/%0b/%0d",
                 k, obs[12:5], obs[4], obs[3], obs[2:0], exp[12:5], exp[4], exp[3], exp[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  // Abort in cycle 4, then a mode-1 restart in cycle 5
  task automatic test_abort();
    string abc = "A.B..A.B.C...", bs = "1111011111100", ds = "0000000000010", ss = "0011000112200";
    logic [12:0] obs, exp;
    byte sd;
    do_reset();
    mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      abort = (k == 4);
      start = (k == 5);
      mode  = (k == 5);
      @(negedge clk);
      sd  = ss[k-1] - 8'h30;
      obs = {letter(a0, b0, c0), busy0, done0, step0};
      exp = {abc[k-1], bs[k-1] == 8'h31, ds[k-1] == 8'h31, sd[2:0]};
      checks++;
      if (obs !== exp)
        $display("FAIL abort cycle %0d: got %c/%0b/%0b/%0d, expected %c/%0b/%0b/%0d",
                 k, obs[12:5], obs[4], obs[3], obs[2:0], exp[12:5], exp[4], exp[3], exp[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; mode = 1'b0;
  endtask

  // Reset in cycle 6, restart with release, ignored start while busy,
  // abort during DONE, then start+abort together in IDLE
  task automatic test_reset_mid();
    string abc = "A.B.A..A.B.C...A.", bs = "11111101111110011";
    string ds = "00000000000001000", ss = "00112200011220000";
    logic [12:0] obs, exp;
    byte sd;
    int y0;
    do_reset();
    y0 = y_count;
    mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      rst   = (k != 6);
      start = (k == 7) || (k == 9) || (k == 15);
      mode  = (k == 7);
      abort = (k == 14) || (k == 15);
      @(negedge clk);
      sd  = ss[k-1] - 8'h30;
      obs = {letter(a0, b0, c0), busy0, done0, step0};
      exp = {abc[k-1], bs[k-1] == 8'h31, ds[k-1] == 8'h31, sd[2:0]};
      checks++;
      if (obs !== exp)
        $display("FAIL reset_mid cycle %0d: got %c/%0b/%0b/%0d, expected %c/%0b/%0b/%0d",
                 k, obs[12:5], obs[4], obs[3], obs[2:0], exp[12:5], exp[4], exp[3], exp[2:0]);
      else passed++;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; mode = 1'b0; rst = 1'b1;
    checks++;
    if (y_count !== y0 + 1) $display("FAIL reset_mid_detect: got %0d, expected %0d", y_count - y0, 1);
    else passed++;
  endtask

  task automatic test_onehot();
    checks++;
    if (multi_count !== 0) $display("FAIL onehot: got %0d multi-high cycles, expected 0", multi_count);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; passed = 0; y_count = 0; multi_count = 0;
    det_prev = "."; det_h1 = "."; det_h2 = "."; det_cur = ".";
    rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_wide();
    test_abort();
    test_reset_mid();
    test_onehot();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/abc_seq_gen.md
ABC_SEQ_GEN -- requirements
Module: abc_seq_gen

Interface
REQ-001 Parameter PULSE_CYC, default 1, the number of cycles each A/B/C pulse is held high; the legal range SHALL be 1..255.
REQ-002 Parameter GAP_CYC, default 1, the number of all-low cycles after each pulse; the legal range SHALL be 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge triggered.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port start, input, 1 bit: request to emit one sequence.
REQ-006 Port mode, input, 1 bit: sequence select, sampled with start; 0 = A,B,A,B,C and 1 = A,B,C.
REQ-007 Port abort, input, 1 bit: terminate the sequence in progress.
REQ-008 Ports A, B, C, output, 1 bit each: registered stimulus pulses for the sequence detector.
REQ-009 Port busy, output, 1 bit: high while a sequence is in progress.
REQ-010 Port done, output, 1 bit: one-cycle completion strobe.
REQ-011 Port step, output, 3 bits: index of the current sequence element, 0..4.

Function
REQ-012 The state machine SHALL have four states: IDLE, PULSE, GAP, DONE.
REQ-013 In IDLE, when start=1 is sampled, the block SHALL latch mode, set step=0, and enter PULSE on the next cycle.
- Latency: the first pulse SHALL appear in the cycle after start is sampled.
REQ-014 In PULSE, the block SHALL drive exactly the output selected by the sequence table at step, for PULSE_CYC cycles, and then enter GAP.
REQ-015 In GAP, A, B and C SHALL all be 0 for GAP_CYC cycles.
- If step is the last index (4 for mode 0, 2 for mode 1), the block SHALL then enter DONE.
- Otherwise it SHALL increment step and enter PULSE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 busy SHALL be 1 in PULSE and GAP, and 0 in IDLE and DONE.
REQ-018 At most one of A, B, C SHALL be high in any cycle; all outputs SHALL come directly from flops (no combinational path from inputs to outputs).
REQ-019 start SHALL be ignored in every state other than IDLE; the latched mode SHALL NOT change mid-sequence.
REQ-020 abort=1 in PULSE or GAP SHALL force IDLE on the next edge, with A/B/C/busy=0, step=0 and no done pulse.
REQ-021 abort in IDLE or DONE SHALL have no effect.
REQ-022 If abort and start are both 1 in IDLE, start SHALL win.
REQ-023 The cycle counter SHALL be 8 bits wide, loaded with PULSE_CYC-1 or GAP_CYC-1 on state entry, and SHALL advance state when it reaches 0.
- The counter SHALL never wrap.
REQ-024 step SHALL hold its value through GAP and SHALL read 0 in IDLE and DONE.

Reset
REQ-025 When rst=0 is sampled at a clock edge, the block SHALL enter IDLE, clear the counter, and drive A=B=C=busy=done=0 and step=0, regardless of the current state.
REQ-026 Reset SHALL take priority over start and abort.
REQ-027 A reset asserted mid-sequence SHALL terminate it without a done pulse.
- After rst returns to 1, the block SHALL accept start on the first edge.

Structure
REQ-028 The state encodings (IDLE=0, PULSE=1, GAP=2, DONE=3), the step-to-output sequence tables for both modes, and the last-step constants (4 and 2) SHALL live in a shared package/header, abc_seq_pkg.
REQ-029 The pacing counter SHALL be one sub-module, seq_cycle_cnt, with ports load, load_val[7:0], and zero; the FSM and output registers SHALL stay in abc_seq_gen.

Verification
REQ-030 Defaults, mode=0, start pulsed at edge 0 -> A=1 in cycle 1, B=1 in cycle 3, A=1 in cycle 5, B=1 in cycle 7, C=1 in cycle 9; done=1 only in cycle 11; busy=1 in cycles 1-10.
REQ-031 Defaults, mode=1 -> A in cycle 1, B in cycle 3, C in cycle 5; done in cycle 7; step reads 0, 1, 2 during the pulses.
REQ-032 PULSE_CYC=3, GAP_CYC=2, mode=1 -> each pulse is 3 cycles wide, separated by 2 low cycles; done in cycle 16.
REQ-033 Defaults, abort asserted in cycle 4 -> outputs all 0 and state IDLE from cycle 5; no done; a new start is accepted immediately.
REQ-034 Defaults, rst=0 in cycle 6 mid-sequence -> all outputs 0 from the next edge; after release, a mode=1 start gives the correct A,B,C sequence; start pulses during busy are ignored.
REQ-035 Closed loop with the sequence detector: mode 0 and mode 1 sequences -> the detector's y asserts on the C pulse; a checker flags any cycle with more than one of A/B/C high.
